// File: rtl/dram_arb_pkg.sv
// Shared definitions for the DRAM access arbiter: FSM state encoding and the
// bit positions inside the sticky error register.
package dram_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_CMD  = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_CMD  = 3'd3,
    ST_WR_DATA = 3'd4,
    ST_WR_RESP = 3'd5
  } dram_arb_state_t;

  // err_sticky[ERR_DROP_BIT]  : a request arrived while that path already held one
  // err_sticky[ERR_RLAST_BIT] : m_rlast did not coincide with the expected last beat
  localparam int unsigned ERR_DROP_BIT  = 0;
  localparam int unsigned ERR_RLAST_BIT = 1;
  localparam int unsigned ERR_WIDTH     = 2;

endpackage

// File: rtl/dram_req_latch.sv
// One-deep request holder for a single arbiter path.
// Ports:
//   clk, rst         : clock, asynchronous active-high reset
//   req_en           : one-cycle burst request strobe
//   req_addr/req_len : request fields, captured with req_en
//   clear            : command handshake for this path; frees the holder
//   pending          : a request is held and not yet handed to the DRAM master
//   addr/len         : held request fields
//   drop             : pulse, a request arrived while one was already held
module dram_req_latch
  import dram_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 39
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_en,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [7:0]            req_len,
  input  logic                  clear,
  output logic                  pending,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [7:0]            len,
  output logic                  drop
);

  logic                  pending_q, pending_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic                  accept_s;

  // Accept when empty or when the held request is leaving this very cycle,
  // so a back-to-back request during the handshake is never lost.
  always_comb begin
    accept_s  = req_en & (~pending_q | clear);
    drop      = req_en & pending_q & ~clear;
    pending_d = pending_q;
    addr_d    = addr_q;
    len_d     = len_q;
    if (accept_s) begin
      pending_d = 1'b1;
      addr_d    = req_addr;
      len_d     = req_len;
    end else if (clear) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
  end

  // Request holder registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= 1'b0;
      addr_q    <= {ADDR_WIDTH{1'b0}};
      len_q     <= 8'd0;
    end else begin
      pending_q <= pending_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
    end
  end

  assign pending = pending_q;
  assign addr    = addr_q;
  assign len     = len_q;

endmodule

// File: rtl/dram_access_arbiter.sv
// Single-port DRAM arbiter between the display read path and the AXI upload
// write path. One burst at a time is issued to the DRAM master; reads win
// arbitration unless a waiting write has already been passed over
// STARVE_LIMIT times.
// Ports:
//   s_axi_aclk, reset                 : clock, asynchronous active-high reset
//   dram_read_*                       : read request, returned beats, back-pressure, busy
//   dram_write_*                      : write request, write beats, ready, busy
//   m_cmd_*                           : burst command to the DRAM master (registered)
//   m_w*, m_r*, m_bdone               : DRAM master data channels and write completion
//   err_sticky                        : [0] dropped request, [1] rlast/beat-count mismatch
module dram_access_arbiter
  import dram_arb_pkg::*;
#(
  parameter int unsigned DRAM_ADDR_WIDTH = 39,
  parameter int unsigned DRAM_DATA_WIDTH = 128,
  parameter int unsigned STARVE_LIMIT    = 4
) (
  input  logic                       s_axi_aclk,
  input  logic                       reset,
  input  logic                       dram_read_en,
  input  logic [DRAM_ADDR_WIDTH-1:0] dram_read_addr,
  input  logic [7:0]                 dram_read_len,
  output logic [DRAM_DATA_WIDTH-1:0] dram_read_data,
  output logic                       dram_read_data_valid,
  input  logic                       dram_buffer_full,
  output logic                       dram_read_busy,
  input  logic                       dram_write_en,
  input  logic [DRAM_ADDR_WIDTH-1:0] dram_write_addr,
  input  logic [7:0]                 dram_write_len,
  input  logic [DRAM_DATA_WIDTH-1:0] dram_write_data,
  input  logic                       dram_write_data_valid,
  output logic                       dram_write_data_ready,
  output logic                       dram_write_busy,
  output logic                       m_cmd_valid,
  input  logic                       m_cmd_ready,
  output logic                       m_cmd_write,
  output logic [DRAM_ADDR_WIDTH-1:0] m_cmd_addr,
  output logic [7:0]                 m_cmd_len,
  output logic [DRAM_DATA_WIDTH-1:0] m_wdata,
  output logic                       m_wvalid,
  input  logic                       m_wready,
  output logic                       m_wlast,
  input  logic [DRAM_DATA_WIDTH-1:0] m_rdata,
  input  logic                       m_rvalid,
  output logic                       m_rready,
  input  logic                       m_rlast,
  input  logic                       m_bdone,
  output logic [ERR_WIDTH-1:0]       err_sticky
);

  localparam int unsigned     SC_W       = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);
  localparam logic [SC_W-1:0] STARVE_ONE = SC_W'(1'b1);

  dram_arb_state_t            state_q, state_d;
  logic                       cmd_valid_q, cmd_valid_d;
  logic                       cmd_write_q, cmd_write_d;
  logic [DRAM_ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
  logic [7:0]                 cmd_len_q, cmd_len_d;
  logic [8:0]                 beat_cnt_q, beat_cnt_d;
  logic [SC_W-1:0]            starve_cnt_q, starve_cnt_d;
  logic [ERR_WIDTH-1:0]       err_q, err_d;

  logic                       rd_pending_s, wr_pending_s;
  logic [DRAM_ADDR_WIDTH-1:0] rd_addr_s, wr_addr_s;
  logic [7:0]                 rd_len_s, wr_len_s;
  logic                       rd_drop_s, wr_drop_s;
  logic                       rd_clear_s, wr_clear_s;
  logic                       grant_rd_s;
  logic                       rd_beat_s, wr_beat_s;
  logic                       last_beat_s;
  logic                       rlast_err_s;
  logic [8:0]                 beat_cnt_inc_s;

  dram_req_latch #(.ADDR_WIDTH(DRAM_ADDR_WIDTH)) u_rd_latch (
    .clk      (s_axi_aclk),
    .rst      (reset),
    .req_en   (dram_read_en),
    .req_addr (dram_read_addr),
    .req_len  (dram_read_len),
    .clear    (rd_clear_s),
    .pending  (rd_pending_s),
    .addr     (rd_addr_s),
    .len      (rd_len_s),
    .drop     (rd_drop_s)
  );

  dram_req_latch #(.ADDR_WIDTH(DRAM_ADDR_WIDTH)) u_wr_latch (
    .clk      (s_axi_aclk),
    .rst      (reset),
    .req_en   (dram_write_en),
    .req_addr (dram_write_addr),
    .req_len  (dram_write_len),
    .clear    (wr_clear_s),
    .pending  (wr_pending_s),
    .addr     (wr_addr_s),
    .len      (wr_len_s),
    .drop     (wr_drop_s)
  );

  // A read loses the arbitration only when a write has already waited through
  // STARVE_LIMIT read grants.
  assign grant_rd_s  = rd_pending_s & ~(wr_pending_s & (starve_cnt_q == STARVE_MAX));
  assign last_beat_s = (beat_cnt_q == {1'b0, cmd_len_q});
  // Beat counter saturates instead of wrapping if rlast never arrives.
  assign beat_cnt_inc_s = (beat_cnt_q == 9'h1FF) ? beat_cnt_q : (beat_cnt_q + 9'd1);

  // Next-state, command register and data-path steering.
  always_comb begin
    state_d               = state_q;
    cmd_valid_d           = cmd_valid_q;
    cmd_write_d           = cmd_write_q;
    cmd_addr_d            = cmd_addr_q;
    cmd_len_d             = cmd_len_q;
    beat_cnt_d            = beat_cnt_q;
    starve_cnt_d          = starve_cnt_q;
    rd_clear_s            = 1'b0;
    wr_clear_s            = 1'b0;
    rd_beat_s             = 1'b0;
    wr_beat_s             = 1'b0;
    rlast_err_s           = 1'b0;
    m_rready              = 1'b0;
    m_wvalid              = 1'b0;
    m_wlast               = 1'b0;
    m_wdata               = {DRAM_DATA_WIDTH{1'b0}};
    dram_write_data_ready = 1'b0;
    dram_read_data        = {DRAM_DATA_WIDTH{1'b0}};
    dram_read_data_valid  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (grant_rd_s) begin
          state_d     = ST_RD_CMD;
          cmd_valid_d = 1'b1;
          cmd_write_d = 1'b0;
          cmd_addr_d  = rd_addr_s;
          cmd_len_d   = rd_len_s;
          beat_cnt_d  = 9'd0;
          if (wr_pending_s) begin
            starve_cnt_d = starve_cnt_q + STARVE_ONE;
          end else begin
            starve_cnt_d = starve_cnt_q;
          end
        end else if (wr_pending_s) begin
          state_d      = ST_WR_CMD;
          cmd_valid_d  = 1'b1;
          cmd_write_d  = 1'b1;
          cmd_addr_d   = wr_addr_s;
          cmd_len_d    = wr_len_s;
          beat_cnt_d   = 9'd0;
          starve_cnt_d = {SC_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RD_CMD: begin
        if (m_cmd_ready) begin
          state_d     = ST_RD_DATA;
          cmd_valid_d = 1'b0;
          rd_clear_s  = 1'b1;
        end else begin
          state_d = ST_RD_CMD;
        end
      end

      ST_RD_DATA: begin
        m_rready             = ~dram_buffer_full;
        rd_beat_s            = m_rvalid & ~dram_buffer_full;
        dram_read_data_valid = rd_beat_s;
        dram_read_data       = rd_beat_s ? m_rdata : {DRAM_DATA_WIDTH{1'b0}};
        if (rd_beat_s) begin
          beat_cnt_d = beat_cnt_inc_s;
          if (m_rlast) begin
            state_d     = ST_IDLE;
            rlast_err_s = ~last_beat_s;
          end else begin
            state_d = ST_RD_DATA;
          end
        end else begin
          state_d = ST_RD_DATA;
        end
      end

      ST_WR_CMD: begin
        if (m_cmd_ready) begin
          state_d     = ST_WR_DATA;
          cmd_valid_d = 1'b0;
          wr_clear_s  = 1'b1;
        end else begin
          state_d = ST_WR_CMD;
        end
      end

      ST_WR_DATA: begin
        m_wvalid              = dram_write_data_valid;
        m_wdata               = dram_write_data;
        m_wlast               = last_beat_s;
        dram_write_data_ready = m_wready;
        wr_beat_s             = dram_write_data_valid & m_wready;
        if (wr_beat_s) begin
          beat_cnt_d = beat_cnt_inc_s;
          state_d    = last_beat_s ? ST_WR_RESP : ST_WR_DATA;
        end else begin
          state_d = ST_WR_DATA;
        end
      end

      ST_WR_RESP: begin
        if (m_bdone) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WR_RESP;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        cmd_valid_d = 1'b0;
      end
    endcase

    err_d                = err_q;
    err_d[ERR_DROP_BIT]  = err_q[ERR_DROP_BIT] | rd_drop_s | wr_drop_s;
    err_d[ERR_RLAST_BIT] = err_q[ERR_RLAST_BIT] | rlast_err_s;
  end

  // FSM state, command and bookkeeping registers.
  always_ff @(posedge s_axi_aclk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cmd_valid_q  <= 1'b0;
      cmd_write_q  <= 1'b0;
      cmd_addr_q   <= {DRAM_ADDR_WIDTH{1'b0}};
      cmd_len_q    <= 8'd0;
      beat_cnt_q   <= 9'd0;
      starve_cnt_q <= {SC_W{1'b0}};
      err_q        <= {ERR_WIDTH{1'b0}};
    end else begin
      state_q      <= state_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_write_q  <= cmd_write_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_len_q    <= cmd_len_d;
      beat_cnt_q   <= beat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      err_q        <= err_d;
    end
  end

  assign m_cmd_valid     = cmd_valid_q;
  assign m_cmd_write     = cmd_write_q;
  assign m_cmd_addr      = cmd_addr_q;
  assign m_cmd_len       = cmd_len_q;
  assign err_sticky      = err_q;
  assign dram_read_busy  = rd_pending_s | (state_q == ST_RD_CMD) | (state_q == ST_RD_DATA);
  assign dram_write_busy = wr_pending_s | (state_q == ST_WR_CMD) | (state_q == ST_WR_DATA)
                         | (state_q == ST_WR_RESP);

endmodule

// File: tb/tb_dram_access_arbiter.sv
// Directed, scoreboard-based bench for dram_access_arbiter. Expected commands,
// read beats and write beats are queued as stimulus is driven and popped
// whenever the DUT presents a handshake.
module tb_dram_access_arbiter;
  import dram_arb_pkg::*;

  logic         clk;
  logic         reset;
  logic         dram_read_en;
  logic [38:0]  dram_read_addr;
  logic [7:0]   dram_read_len;
  logic [127:0] dram_read_data;
  logic         dram_read_data_valid;
  logic         dram_buffer_full;
  logic         dram_read_busy;
  logic         dram_write_en;
  logic [38:0]  dram_write_addr;
  logic [7:0]   dram_write_len;
  logic [127:0] dram_write_data;
  logic         dram_write_data_valid;
  logic         dram_write_data_ready;
  logic         dram_write_busy;
  logic         m_cmd_valid;
  logic         m_cmd_ready;
  logic         m_cmd_write;
  logic [38:0]  m_cmd_addr;
  logic [7:0]   m_cmd_len;
  logic [127:0] m_wdata;
  logic         m_wvalid;
  logic         m_wready;
  logic         m_wlast;
  logic [127:0] m_rdata;
  logic         m_rvalid;
  logic         m_rready;
  logic         m_rlast;
  logic         m_bdone;
  logic [1:0]   err_sticky;

  typedef struct {
    logic        write;
    logic [38:0] addr;
    logic [7:0]  len;
  } cmd_t;

  cmd_t         cmd_q[$];
  logic [127:0] rd_q[$];
  logic [128:0] wr_q[$];
  int           checks   = 0;
  int           failures = 0;

  dram_access_arbiter #(
    .DRAM_ADDR_WIDTH(39), .DRAM_DATA_WIDTH(128), .STARVE_LIMIT(4)
  ) dut (
    .s_axi_aclk(clk), .reset(reset),
    .dram_read_en(dram_read_en), .dram_read_addr(dram_read_addr),
    .dram_read_len(dram_read_len), .dram_read_data(dram_read_data),
    .dram_read_data_valid(dram_read_data_valid), .dram_buffer_full(dram_buffer_full),
    .dram_read_busy(dram_read_busy),
    .dram_write_en(dram_write_en), .dram_write_addr(dram_write_addr),
    .dram_write_len(dram_write_len), .dram_write_data(dram_write_data),
    .dram_write_data_valid(dram_write_data_valid),
    .dram_write_data_ready(dram_write_data_ready), .dram_write_busy(dram_write_busy),
    .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready), .m_cmd_write(m_cmd_write),
    .m_cmd_addr(m_cmd_addr), .m_cmd_len(m_cmd_len),
    .m_wdata(m_wdata), .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wlast(m_wlast),
    .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rlast(m_rlast),
    .m_bdone(m_bdone), .err_sticky(err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare every handshake that will complete at the coming edge.
  task automatic monitor();
    cmd_t         c;
    logic [127:0] r;
    logic [128:0] w;
    if (m_cmd_valid === 1'b1 && m_cmd_ready === 1'b1) begin
      if (cmd_q.size() == 0) chk("cmd_unexpected", 256'(1'b1), 256'(1'b0));
      else begin
        c = cmd_q.pop_front();
        chk("cmd_write", 256'(m_cmd_write), 256'(c.write));
        chk("cmd_addr", 256'(m_cmd_addr), 256'(c.addr));
        chk("cmd_len", 256'(m_cmd_len), 256'(c.len));
      end
    end
    if (dram_read_data_valid === 1'b1) begin
      if (rd_q.size() == 0) chk("rd_unexpected", 256'(1'b1), 256'(1'b0));
      else begin
        r = rd_q.pop_front();
        chk("rd_data", 256'(dram_read_data), 256'(r));
      end
    end
    if (m_wvalid === 1'b1 && m_wready === 1'b1) begin
      if (wr_q.size() == 0) chk("wr_unexpected", 256'(1'b1), 256'(1'b0));
      else begin
        w = wr_q.pop_front();
        chk("wr_data", 256'(m_wdata), 256'(w[127:0]));
        chk("wr_last", 256'(m_wlast), 256'(w[128]));
      end
    end
  endtask

  // Sample at the falling edge, then step past the rising edge to drive.
  task automatic cyc();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #2;
  endtask

  task automatic push_cmd(input logic w, input logic [38:0] a, input logic [7:0] l);
    cmd_t c;
    c.write = w; c.addr = a; c.len = l;
    cmd_q.push_back(c);
  endtask

  task automatic wait_cmd();
    int n = 0;
    while (m_cmd_valid !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    chk("cmd_wait", 256'(n < 20), 256'(1'b1));
    cyc();
  endtask

  task automatic rd_data(input logic [7:0] len, input logic [127:0] seed,
                         input logic nxt, input logic [38:0] nxt_addr);
    for (int i = 0; i <= int'(len); i++) begin
      m_rvalid = 1'b1;
      m_rdata  = seed + 128'(i);
      m_rlast  = (i == int'(len));
      rd_q.push_back(seed + 128'(i));
      if (i == 0 && nxt) begin
        dram_read_en   = 1'b1;
        dram_read_addr = nxt_addr;
        dram_read_len  = 8'd1;
      end
      cyc();
      dram_read_en = 1'b0;
    end
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
  endtask

  task automatic wr_data(input logic [7:0] len, input logic [127:0] seed);
    for (int i = 0; i <= int'(len); i++) begin
      dram_write_data_valid = 1'b1;
      m_wready              = 1'b1;
      dram_write_data       = seed + 128'(i);
      wr_q.push_back({(i == int'(len)), seed + 128'(i)});
      cyc();
    end
    dram_write_data_valid = 1'b0;
    m_wready              = 1'b0;
    m_bdone               = 1'b1;
    cyc();
    m_bdone = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rdata"}, 256'(dram_read_data), 256'(128'd0));
    chk({tag, "_rvalid_o"}, 256'(dram_read_data_valid), 256'(1'b0));
    chk({tag, "_rbusy"}, 256'(dram_read_busy), 256'(1'b0));
    chk({tag, "_wready_o"}, 256'(dram_write_data_ready), 256'(1'b0));
    chk({tag, "_wbusy"}, 256'(dram_write_busy), 256'(1'b0));
    chk({tag, "_cmd_valid"}, 256'(m_cmd_valid), 256'(1'b0));
    chk({tag, "_cmd_write"}, 256'(m_cmd_write), 256'(1'b0));
    chk({tag, "_cmd_addr"}, 256'(m_cmd_addr), 256'(39'd0));
    chk({tag, "_cmd_len"}, 256'(m_cmd_len), 256'(8'd0));
    chk({tag, "_wdata"}, 256'(m_wdata), 256'(128'd0));
    chk({tag, "_wvalid"}, 256'(m_wvalid), 256'(1'b0));
    chk({tag, "_wlast"}, 256'(m_wlast), 256'(1'b0));
    chk({tag, "_rready"}, 256'(m_rready), 256'(1'b0));
    chk({tag, "_err"}, 256'(err_sticky), 256'(2'b00));
    chk({tag, "_state"}, 256'(dut.state_q), 256'(ST_IDLE));
  endtask

  initial begin
    int idx;
    reset = 1'b1;
    dram_read_en = 1'b0; dram_read_addr = 39'd0; dram_read_len = 8'd0;
    dram_buffer_full = 1'b0;
    dram_write_en = 1'b0; dram_write_addr = 39'd0; dram_write_len = 8'd0;
    dram_write_data = 128'd0; dram_write_data_valid = 1'b0;
    m_cmd_ready = 1'b1; m_wready = 1'b0;
    m_rdata = 128'd0; m_rvalid = 1'b0; m_rlast = 1'b0; m_bdone = 1'b0;
    cyc(); cyc();
    #1 check_zero("reset");
    reset = 1'b0;
    cyc();

    // Read only: addr 0x1000, len 3.
    dram_read_en = 1'b1; dram_read_addr = 39'h1000; dram_read_len = 8'd3;
    push_cmd(1'b0, 39'h1000, 8'd3);
    cyc();
    dram_read_en = 1'b0;
    #1 chk("rd_busy_rise", 256'(dram_read_busy), 256'(1'b1));
    chk("rd_cmd_not_yet", 256'(m_cmd_valid), 256'(1'b0));
    cyc();
    #1 chk("rd_cmd_valid_2cyc", 256'(m_cmd_valid), 256'(1'b1));
    chk("rd_cmd_is_read", 256'(m_cmd_write), 256'(1'b0));
    cyc();
    rd_data(8'd3, 128'hA0, 1'b0, 39'd0);
    #1 chk("rd_busy_fall", 256'(dram_read_busy), 256'(1'b0));

    // Write only: len 1 with m_wready toggling.
    dram_write_en = 1'b1; dram_write_addr = 39'h2000; dram_write_len = 8'd1;
    push_cmd(1'b1, 39'h2000, 8'd1);
    cyc();
    dram_write_en = 1'b0;
    #1 chk("wr_busy_rise", 256'(dram_write_busy), 256'(1'b1));
    wait_cmd();
    wr_q.push_back({1'b0, 128'hB0});
    wr_q.push_back({1'b1, 128'hB1});
    idx = 0;
    for (int k = 0; k < 4; k++) begin
      m_wready = k[0];
      dram_write_data_valid = 1'b1;
      dram_write_data = (idx == 0) ? 128'hB0 : 128'hB1;
      #1 chk("wr_ready_pass", 256'(dram_write_data_ready), 256'(m_wready));
      chk("wr_wlast_cnt", 256'(m_wlast), 256'(idx == 1));
      cyc();
      if (m_wready) idx++;
    end
    dram_write_data_valid = 1'b0; m_wready = 1'b0;
    cyc(); cyc();
    #1 chk("wr_busy_until_bdone", 256'(dram_write_busy), 256'(1'b1));
    chk("wr_wvalid_resp", 256'(m_wvalid), 256'(1'b0));
    m_bdone = 1'b1;
    cyc();
    m_bdone = 1'b0;
    #1 chk("wr_busy_fall", 256'(dram_write_busy), 256'(1'b0));

    // Simultaneous requests: read first, then write.
    dram_read_en = 1'b1; dram_read_addr = 39'h3000; dram_read_len = 8'd0;
    dram_write_en = 1'b1; dram_write_addr = 39'h4000; dram_write_len = 8'd0;
    push_cmd(1'b0, 39'h3000, 8'd0);
    push_cmd(1'b1, 39'h4000, 8'd0);
    cyc();
    dram_read_en = 1'b0; dram_write_en = 1'b0;
    cyc();
    #1 chk("sim_starve_1", 256'(dut.starve_cnt_q), 256'(3'd1));
    chk("sim_first_read", 256'(m_cmd_write), 256'(1'b0));
    cyc();
    rd_data(8'd0, 128'hC0, 1'b0, 39'd0);
    wait_cmd();
    #1 chk("sim_starve_0", 256'(dut.starve_cnt_q), 256'(3'd0));
    wr_data(8'd0, 128'hD0);
    #1 chk("sim_idle_busy", 256'({dram_read_busy, dram_write_busy}), 256'(2'b00));

    // Starvation: write pending across back-to-back reads, limit 4.
    push_cmd(1'b0, 39'h8000, 8'd1);
    push_cmd(1'b0, 39'h8100, 8'd1);
    push_cmd(1'b0, 39'h8200, 8'd1);
    push_cmd(1'b0, 39'h8300, 8'd1);
    push_cmd(1'b1, 39'h9000, 8'd0);
    push_cmd(1'b0, 39'h8400, 8'd1);
    push_cmd(1'b0, 39'h8500, 8'd1);
    dram_read_en = 1'b1; dram_read_addr = 39'h8000; dram_read_len = 8'd1;
    dram_write_en = 1'b1; dram_write_addr = 39'h9000; dram_write_len = 8'd0;
    cyc();
    dram_read_en = 1'b0; dram_write_en = 1'b0;
    wait_cmd(); rd_data(8'd1, 128'h100, 1'b1, 39'h8100);
    wait_cmd(); rd_data(8'd1, 128'h110, 1'b1, 39'h8200);
    wait_cmd(); rd_data(8'd1, 128'h120, 1'b1, 39'h8300);
    wait_cmd();
    #1 chk("starve_at_limit", 256'(dut.starve_cnt_q), 256'(3'd4));
    rd_data(8'd1, 128'h130, 1'b1, 39'h8400);
    wait_cmd();
    #1 chk("starve_cleared", 256'(dut.starve_cnt_q), 256'(3'd0));
    wr_data(8'd0, 128'h190);
    wait_cmd(); rd_data(8'd1, 128'h140, 1'b1, 39'h8500);
    wait_cmd(); rd_data(8'd1, 128'h150, 1'b0, 39'd0);
    chk("starve_cmds_done", 256'(cmd_q.size()), 256'(0));

    // Buffer full mid-read.
    dram_read_en = 1'b1; dram_read_addr = 39'h5000; dram_read_len = 8'd3;
    push_cmd(1'b0, 39'h5000, 8'd3);
    cyc();
    dram_read_en = 1'b0;
    wait_cmd();
    m_rvalid = 1'b1; m_rdata = 128'hE0; m_rlast = 1'b0;
    rd_q.push_back(128'hE0);
    cyc();
    dram_buffer_full = 1'b1; m_rdata = 128'hE1;
    for (int k = 0; k < 2; k++) begin
      #1 chk("full_rready", 256'(m_rready), 256'(1'b0));
      chk("full_no_valid", 256'(dram_read_data_valid), 256'(1'b0));
      cyc();
    end
    dram_buffer_full = 1'b0;
    for (int i = 1; i < 4; i++) begin
      m_rdata = 128'hE0 + 128'(i); m_rlast = (i == 3);
      rd_q.push_back(128'hE0 + 128'(i));
      cyc();
    end
    m_rvalid = 1'b0; m_rlast = 1'b0;
    #1 chk("full_busy_fall", 256'(dram_read_busy), 256'(1'b0));

    // Errors: dropped request, then early rlast.
    dram_read_en = 1'b1; dram_read_addr = 39'h6000; dram_read_len = 8'd3;
    push_cmd(1'b0, 39'h6000, 8'd3);
    #1 chk("err_before", 256'(err_sticky), 256'(2'b00));
    cyc();
    dram_read_addr = 39'h6100;
    cyc();
    dram_read_en = 1'b0;
    #1 chk("err_drop", 256'(err_sticky), 256'(2'b01));
    wait_cmd();
    rd_data(8'd2, 128'hF0, 1'b0, 39'd0);
    #1 chk("err_rlast", 256'(err_sticky), 256'(2'b11));
    chk("err_rd_idle", 256'(dram_read_busy), 256'(1'b0));

    // Reset mid-WR_DATA.
    dram_write_en = 1'b1; dram_write_addr = 39'h7000; dram_write_len = 8'd3;
    push_cmd(1'b1, 39'h7000, 8'd3);
    cyc();
    dram_write_en = 1'b0;
    wait_cmd();
    dram_write_data_valid = 1'b1; m_wready = 1'b1; dram_write_data = 128'h70;
    wr_q.push_back({1'b0, 128'h70});
    cyc();
    dram_write_data = 128'h71;
    reset = 1'b1;
    #1 check_zero("midreset");
    dram_write_data_valid = 1'b0; m_wready = 1'b0;
    cyc();
    reset = 1'b0;
    cyc();
    #1 chk("post_reset_state", 256'(dut.state_q), 256'(ST_IDLE));
    chk("post_reset_wbusy", 256'(dram_write_busy), 256'(1'b0));

    chk("end_cmd_q", 256'(cmd_q.size()), 256'(0));
    chk("end_rd_q", 256'(rd_q.size()), 256'(0));
    chk("end_wr_q", 256'(wr_q.size()), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
